mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline, between the X/M pipeline register and reg_MW.
- Runs lw/sw against a multi-cycle data memory using a req/ack handshake.
- Stalls upstream stages until the access completes or times out.
- Presents pc, instr, O (ALU result/address), D (load data) and E (3-bit exception code) to reg_MW.

Parameters:
- ADDR_W, 12, implemented data-memory word-address width; O_in bits above it must be zero.
- TIMEOUT, 15, WAIT cycles without mem_ack before the access aborts with a bus error.

Ports:
- clock  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- pc_in  in  32  PC from X/M
- instr_in  in  32  instruction from X/M
- O_in  in  32  ALU result / word address from X/M
- B_in  in  32  store data from X/M
- E_in  in  3  exception code from X/M (0 = none)
- mem_req  out  1  registered request to data memory
- mem_we  out  1  registered write enable (1 = sw)
- mem_addr  out  ADDR_W  registered word address
- mem_wdata  out  32  registered store data
- mem_ack  in  1  one-cycle completion pulse from memory
- mem_rdata  in  32  read data, valid when mem_ack = 1
- stall  out  1  holds PC, F/D, D/X and X/M (their enable = ~stall)
- pc_out  out  32  to reg_MW
- instr_out  out  32  to reg_MW
- O_out  out  32  to reg_MW
- D_out  out  32  to reg_MW
- E_out  out  3  to reg_MW

Behaviour:
- Decode:
  - lw = instr_in[31:27] == 5'b01000; sw = 5'b00111.
  - memop = (lw | sw) & (E_in == 0).
  - oor = memop & (O_in[31:ADDR_W] != 0).
- FSM states: IDLE, WAIT, DONE. Reset → IDLE; mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, wait counter = 0, data hold register = 0.
- IDLE, non-memop or oor:
  - stall = 0; outputs pass through combinationally: pc_out = pc_in, instr_out = instr_in, O_out = O_in, E_out = E_in, D_out = 0.
  - oor forces E_out = 3'd7 and issues no request.
- IDLE, memop and not oor:
  - stall = 1; next edge → WAIT.
  - On that edge: mem_req = 1, mem_we = sw, mem_addr = O_in[ADDR_W-1:0], mem_wdata = B_in, counter = 0.
- WAIT:
  - stall = 1; counter increments each cycle.
  - mem_ack = 1 → DONE; capture mem_rdata into the hold register (lw), or 0 (sw); mem_req and mem_we drop on the same edge.
  - counter == TIMEOUT-1 with no ack → DONE; set the bus-error flag; drop mem_req.
  - ack and timeout in the same cycle: ack wins, no error.
- DONE (one cycle):
  - stall = 0; pc/instr/O pass through.
  - D_out = hold register; E_out = 3'd6 if bus error, else 0.
  - Next edge → IDLE.
- While stall = 1, the bubble goes to reg_MW: instr_out = 0, O_out = 0, D_out = 0, E_out = 0, pc_out = pc_in. X/M holds the instruction, so DONE sees the same instruction.
- Latency: a zero-wait-state memory (ack in the first WAIT cycle) gives 2 stall cycles; each extra wait cycle adds 1.
- mem_ack in IDLE or DONE is ignored.
- Reset in any state → IDLE on that edge; mem_req drops the same edge; the in-flight access is abandoned; late acks are ignored.

Decomposition:
- Shared package:
  - opcode constants OP_LW, OP_SW;
  - exception codes EXC_NONE = 0, EXC_BUSERR = 6, EXC_OOR = 7;
  - state encoding IDLE/WAIT/DONE.
- One sub-module, mem_wait_counter: a counter with clear/enable and a terminal-count output at TIMEOUT-1.

Test Plan:
- add (opcode 00000), O_in = 0x15, E_in = 0 → same cycle stall = 0, instr_out = instr_in, O_out = 0x15, D_out = 0, mem_req never asserted.
- lw, O_in = 0x20, mem_ack 2 cycles after mem_req rises with mem_rdata = 0xDEADBEEF:
  - stall high 3 cycles; mem_addr = 0x020, mem_we = 0;
  - DONE cycle gives D_out = 0xDEADBEEF, E_out = 0.
- sw, O_in = 0x7, B_in = 0xCAFEF00D, ack after 1 cycle:
  - mem_we = 1, mem_wdata = 0xCAFEF00D, stall high 2 cycles;
  - DONE gives D_out = 0, E_out = 0.
- lw, no ack:
  - mem_req high exactly 15 cycles, stall high 16 cycles;
  - DONE gives E_out = 6, D_out = 0;
  - an ack arriving afterwards causes no state change.
- lw, O_in = 0x00001000 (bit 12 set) → E_out = 7 same cycle, stall = 0, no mem_req.
- lw, reset asserted in the 2nd WAIT cycle → next edge: mem_req = 0, stall = 0 (IDLE with reset released, instr_in = nop); mem_ack the following cycle is ignored.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory stage: opcodes, exception codes, FSM encoding.
package mem_stage_pkg;

  localparam logic [4:0] OP_LW = 5'b01000;
  localparam logic [4:0] OP_SW = 5'b00111;

  localparam logic [2:0] EXC_NONE   = 3'd0;
  localparam logic [2:0] EXC_BUSERR = 3'd6;
  localparam logic [2:0] EXC_OOR    = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-cycle counter for an outstanding data-memory access.
// Clear wins over enable; tc flags the last cycle before the access is abandoned.
module mem_wait_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: runs lw/sw on a req/ack data memory, stalling upstream meanwhile.
// Latency: 1 issue cycle + wait cycles until ack (or TIMEOUT), then one DONE cycle.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       instr_in,
  input  logic [31:0]       O_in,
  input  logic [31:0]       B_in,
  input  logic [2:0]        E_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              stall,
  output logic [31:0]       pc_out,
  output logic [31:0]       instr_out,
  output logic [31:0]       O_out,
  output logic [31:0]       D_out,
  output logic [2:0]        E_out
);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       hold_q, hold_d;
  logic              berr_q, berr_d;
  logic              cnt_clr, cnt_en, cnt_tc;

  logic is_lw, is_sw, memop, oor;

  assign is_lw = (instr_in[31:27] == OP_LW);
  assign is_sw = (instr_in[31:27] == OP_SW);
  assign memop = (is_lw | is_sw) & (E_in == EXC_NONE);
  assign oor   = memop & (O_in[31:ADDR_W] != '0);

  mem_wait_counter #(.TIMEOUT(TIMEOUT)) u_wait_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    hold_d    = hold_q;
    berr_d    = berr_q;
    cnt_clr   = 1'b1;
    cnt_en    = 1'b0;
    stall     = 1'b0;
    pc_out    = pc_in;
    instr_out = instr_in;
    O_out     = O_in;
    D_out     = '0;
    E_out     = E_in;

    case (state_q)
      IDLE: begin
        if (oor) begin
          E_out = EXC_OOR;
        end else if (memop) begin
          stall   = 1'b1;
          state_d = WAIT;
          req_d   = 1'b1;
          we_d    = is_sw;
          addr_d  = O_in[ADDR_W-1:0];
          wdata_d = B_in;
        end
      end
      WAIT: begin
        stall   = 1'b1;
        cnt_clr = 1'b0;
        cnt_en  = 1'b1;
        // An ack on the terminal cycle still completes cleanly.
        if (mem_ack) begin
          state_d = DONE;
          hold_d  = we_q ? '0 : mem_rdata;
          berr_d  = 1'b0;
          req_d   = 1'b0;
          we_d    = 1'b0;
        end else if (cnt_tc) begin
          state_d = DONE;
          hold_d  = '0;
          berr_d  = 1'b1;
          req_d   = 1'b0;
          we_d    = 1'b0;
        end
      end
      DONE: begin
        D_out   = hold_q;
        E_out   = berr_q ? EXC_BUSERR : EXC_NONE;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Bubble to reg_MW while X/M is held.
    if (stall) begin
      instr_out = '0;
      O_out     = '0;
      D_out     = '0;
      E_out     = EXC_NONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= '0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      berr_q  <= berr_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver issues instructions and plays the data memory,
// monitor pops expected reg_MW values on every non-stalled cycle.
module tb_mem_stage;

  localparam int          TIMEOUT = 15;
  localparam logic [4:0]  LW      = 5'b01000;
  localparam logic [4:0]  SW      = 5'b00111;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_in, instr_in, O_in, B_in;
  logic [2:0]  E_in;
  logic        mem_req, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [31:0] pc_out, instr_out, O_out, D_out;
  logic [2:0]  E_out;

  always #5 clock = ~clock;

  mem_stage #(.ADDR_W(12), .TIMEOUT(TIMEOUT)) dut (
    .clock     (clock),
    .reset     (reset),
    .pc_in     (pc_in),
    .instr_in  (instr_in),
    .O_in      (O_in),
    .B_in      (B_in),
    .E_in      (E_in),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .stall     (stall),
    .pc_out    (pc_out),
    .instr_out (instr_out),
    .O_out     (O_out),
    .D_out     (D_out),
    .E_out     (E_out)
  );

  typedef struct {
    logic [31:0] pc, instr, O, D, wdata;
    logic [2:0]  E;
    logic        we;
    logic [11:0] addr;
    int          stall_cyc;
    int          req_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  // Monitor: bubble checks while stalled, full compare when the stage releases.
  int   st_cnt = 0;
  int   rq_cnt = 0;
  exp_t me;
  always @(negedge clock) begin
    if (reset) begin
      st_cnt = 0;
      rq_cnt = 0;
    end else if (exp_q.size() != 0) begin
      if (mem_req) begin
        rq_cnt++;
        if (exp_q[0].req_cyc > 0) begin
          chk("req_addr",  32'(mem_addr), 32'(exp_q[0].addr));
          chk("req_we",    32'(mem_we),   32'(exp_q[0].we));
          chk("req_wdata", mem_wdata,     exp_q[0].wdata);
        end
      end
      if (stall) begin
        st_cnt++;
        chk("bubble_pc",    pc_out,        exp_q[0].pc);
        chk("bubble_instr", instr_out,     32'd0);
        chk("bubble_O",     O_out,         32'd0);
        chk("bubble_D",     D_out,         32'd0);
        chk("bubble_E",     32'(E_out),    32'd0);
        if (st_cnt > 40) st_cnt = 40;
      end else begin
        me = exp_q.pop_front();
        chk("out_pc",     pc_out,      me.pc);
        chk("out_instr",  instr_out,   me.instr);
        chk("out_O",      O_out,       me.O);
        chk("out_D",      D_out,       me.D);
        chk("out_E",      32'(E_out),  32'(me.E));
        chk("stall_cyc",  32'(st_cnt), 32'(me.stall_cyc));
        chk("req_cyc",    32'(rq_cnt), 32'(me.req_cyc));
        st_cnt = 0;
        rq_cnt = 0;
      end
    end
  end

  // Issue one instruction, answer the memory with an ack in wait cycle L (L > TIMEOUT: never),
  // optionally putting a stray ack on the bus whenever no request is outstanding.
  task automatic run_txn(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] O,
                         input logic [31:0] B, input logic [2:0] E, input int L,
                         input logic [31:0] rdata, input bit stray);
    exp_t       e;
    logic [4:0] op;
    bit         memop, oor, ok, done;
    int         k;
    op    = instr[31:27];
    memop = (op == LW || op == SW) && (E == 3'd0);
    oor   = memop && ((O >> 12) != 0);
    ok    = (L >= 1) && (L <= TIMEOUT);
    e.pc = pc; e.instr = instr; e.O = O; e.wdata = B;
    e.we = (op == SW); e.addr = O[11:0];
    if (!memop) begin
      e.E = E;      e.D = 0; e.stall_cyc = 0; e.req_cyc = 0;
    end else if (oor) begin
      e.E = 3'd7;   e.D = 0; e.stall_cyc = 0; e.req_cyc = 0;
    end else if (ok) begin
      e.E = 3'd0;   e.D = (op == LW) ? rdata : 32'd0;
      e.stall_cyc = 1 + L; e.req_cyc = L;
    end else begin
      e.E = 3'd6;   e.D = 0; e.stall_cyc = 1 + TIMEOUT; e.req_cyc = TIMEOUT;
    end

    @(posedge clock); #1;
    pc_in = pc; instr_in = instr; O_in = O; B_in = B; E_in = E;
    exp_q.push_back(e);
    k    = 0;
    done = 0;
    for (int c = 0; c < 40; c++) begin
      if (mem_req) begin
        k++;
        mem_ack   = (k == L);
        mem_rdata = (k == L) ? rdata : $urandom;
      end else begin
        mem_ack   = stray;
        mem_rdata = $urandom;
      end
      @(negedge clock);
      if (!stall) begin
        done = 1;
        break;
      end
      @(posedge clock); #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL txn_timeout stall still high after 40 cycles, required release");
      exp_q.delete();
    end
  endtask

  logic [4:0]  r_op;
  logic [31:0] r_O;
  logic [2:0]  r_E;
  int          r_L;

  initial begin
    reset = 1'b1;
    pc_in = 0; instr_in = 0; O_in = 0; B_in = 0; E_in = 0;
    mem_ack = 0; mem_rdata = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_mem_req",   32'(mem_req),  32'd0);
    chk("rst_mem_we",    32'(mem_we),   32'd0);
    chk("rst_mem_addr",  32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata,     32'd0);
    chk("rst_stall",     32'(stall),    32'd0);
    chk("rst_D",         D_out,         32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    run_txn(32'h100, {5'b00000, 27'h0123456}, 32'h15, 32'h0, 3'd0, 99, 32'h0, 1'b1);
    run_txn(32'h104, {LW, 27'h0000001}, 32'h20, 32'h0, 3'd0, 2, 32'hDEADBEEF, 1'b0);
    run_txn(32'h108, {SW, 27'h0000002}, 32'h7, 32'hCAFEF00D, 3'd0, 1, 32'h11111111, 1'b0);
    run_txn(32'h10C, {LW, 27'h0000003}, 32'h40, 32'h0, 3'd0, 99, 32'h0, 1'b1);
    run_txn(32'h110, {LW, 27'h0000004}, 32'h1000, 32'h0, 3'd0, 1, 32'h0, 1'b0);
    run_txn(32'h114, {LW, 27'h0000005}, 32'hFFF, 32'h0, 3'd0, TIMEOUT, 32'h5A5A5A5A, 1'b0);
    run_txn(32'h118, {LW, 27'h0000006}, 32'h1, 32'h0, 3'd0, TIMEOUT + 1, 32'h0, 1'b0);
    run_txn(32'h11C, {LW, 27'h0000007}, 32'h1000, 32'h0, 3'd3, 1, 32'h0, 1'b0);

    // Reset in the second wait cycle abandons the access; a late ack must be ignored.
    @(posedge clock); #1;
    pc_in = 32'h200; instr_in = {LW, 27'h0}; O_in = 32'h30; E_in = 0; mem_ack = 0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    instr_in = 32'h0;
    @(negedge clock);
    chk("rstwait_req",   32'(mem_req), 32'd0);
    chk("rstwait_stall", 32'(stall),   32'd0);
    @(posedge clock); #1;
    mem_ack = 1'b1; mem_rdata = 32'hBADBAD00;
    @(negedge clock);
    chk("lateack_stall", 32'(stall),   32'd0);
    @(posedge clock); #1;
    mem_ack = 1'b0;
    @(negedge clock);
    chk("lateack_req",   32'(mem_req), 32'd0);
    chk("lateack_stall2",32'(stall),   32'd0);
    chk("lateack_D",     D_out,        32'd0);
    chk("lateack_E",     32'(E_out),   32'd0);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: r_op = LW;
        4, 5, 6:    r_op = SW;
        7, 8:       r_op = 5'b00000;
        default:    r_op = 5'($urandom_range(0, 31));
      endcase
      r_E = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 5)) : 3'd0;
      r_O = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4095));
      case ($urandom_range(0, 5))
        0, 1, 2: r_L = $urandom_range(1, 4);
        3:       r_L = $urandom_range(5, TIMEOUT);
        4:       r_L = TIMEOUT + 1;
        default: r_L = 99;
      endcase
      run_txn($urandom, {r_op, 27'($urandom)}, r_O, $urandom, r_E, r_L, $urandom,
              1'($urandom_range(0, 1)));
    end

    @(posedge clock); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
